// File: rtl/mem_lsu_if.sv
// Request/response and memory-port bundle for mem_lsu.
// master = core/memory side, slave = the load/store unit.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wen;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_raddr, mem_waddr, mem_wdata, mem_wen
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_raddr, mem_waddr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: one byte/half/word access at a time against a word-wide
// memory without byte enables. Sub-word stores are done as read-modify-write.
module mem_lsu #(
  parameter bit WORD_ADDRESSED = 1'b1
) (
  input logic     clk,
  input logic     rst,
  mem_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        misaligned;
  logic        word_store;
  logic [31:0] word_addr;

  logic        lat_we;
  logic        lat_uns;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;

  logic [31:0] mem_addr;
  logic [31:0] wdata_r;
  logic        err_r;
  logic [31:0] rdata_r;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_r;
  assign bus.resp_rdata = rdata_r;
  assign bus.mem_raddr  = mem_addr;
  assign bus.mem_waddr  = mem_addr;
  assign bus.mem_wdata  = wdata_r;
  assign bus.mem_wen    = (state == WRITE) && !rst;

  assign accept     = bus.req_valid && bus.req_ready;
  assign misaligned = (bus.req_size == 2'd3) ||
                      (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                      (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
  assign word_store = bus.req_we && (bus.req_size == 2'd2);
  assign word_addr  = WORD_ADDRESSED ? {2'b00, bus.req_addr[31:2]}
                                     : {bus.req_addr[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)      state_nxt = RESP;
          else if (word_store) state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      READ:    state_nxt = lat_we ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_b     = bus.mem_rdata[{lat_off, 3'b000} +: 8];
    lane_h     = lat_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_data  = bus.mem_rdata;
    merge_data = bus.mem_rdata;
    case (lat_size)
      2'd0: begin
        load_data = {{24{lane_b[7] & ~lat_uns}}, lane_b};
        merge_data[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
      end
      2'd1: begin
        load_data = {{16{lane_h[15] & ~lat_uns}}, lane_h};
        if (lat_off[1]) merge_data[31:16] = lat_wdata[15:0];
        else            merge_data[15:0]  = lat_wdata[15:0];
      end
      default: ;
    endcase
  end

  // Request latch, memory address/data, and response registers.
  // Response registers load only on the transition into RESP and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= '0;
      lat_off   <= '0;
      lat_wdata <= '0;
      mem_addr  <= '0;
      wdata_r   <= '0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= bus.req_we;
            lat_uns   <= bus.req_unsigned;
            lat_size  <= bus.req_size;
            lat_off   <= bus.req_addr[1:0];
            lat_wdata <= bus.req_wdata;
            mem_addr  <= word_addr;
            if (misaligned) begin
              err_r   <= 1'b1;
              rdata_r <= '0;
            end else if (word_store) begin
              wdata_r <= bus.req_wdata;
            end
          end
        end
        READ: begin
          if (lat_we) begin
            wdata_r <= merge_data;
          end else begin
            err_r   <= 1'b0;
            rdata_r <= load_data;
          end
        end
        WRITE: begin
          err_r   <= 1'b0;
          rdata_r <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random traffic,
// checked against a byte-lane reference model of the memory.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_lsu_if bus();

  mem_lsu #(.WORD_ADDRESSED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned resp_seen = 0;
  int unsigned wen_seen  = 0;
  int unsigned n_req = 0;
  int unsigned n_wr  = 0;

  // Word-wide data memory: write and read-data register on the falling edge.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h9E37_79B9 * (i + 1);
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_wen) mem[bus.mem_waddr[5:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_raddr[5:0]];
    end
  end

  // Global strobe counters.
  always @(negedge clk) begin
    if (bus.resp_valid) resp_seen <= resp_seen + 1;
    if (bus.mem_wen)    wen_seen  <= wen_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
  endfunction

  // One request; expected response computed from the reference model.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, input string tag);
    int unsigned w, nbytes, sh, exp_lat, lat, wens, exp_wen;
    logic [31:0] mask, exp_rd, exp_wd, v, idx;
    bit got_resp;

    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      check_eq({tag, " ready timeout"}, 32'(bus.req_ready), 32'd1);
      return;
    end

    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n_req++;

    idx    = {26'b0, addr[7:2]};
    sh     = 8 * addr[1:0];
    nbytes = 1 << size;
    mask   = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
    exp_rd = '0;
    exp_wd = '0;
    exp_wen = 0;
    if (is_misaligned(size, addr)) begin
      exp_lat = 1;
    end else if (we) begin
      exp_wd  = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[idx] = exp_wd;
      exp_lat = (size == 2'd2) ? 2 : 3;
      exp_wen = 1;
      n_wr++;
    end else begin
      v = (ref_mem[idx] >> sh) & mask;
      if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
      exp_rd  = v;
      exp_lat = 2;
    end

    @(posedge clk);
    lat = 0;
    wens = 0;
    got_resp = 0;
    for (int c = 1; c <= 8 && !got_resp; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          bus.req_we       = $urandom_range(1);
          bus.req_size     = 2'($urandom_range(3));
          bus.req_unsigned = $urandom_range(1);
          bus.req_addr     = $urandom_range(255);
          bus.req_wdata    = $urandom;
        end else begin
          bus.req_valid = 1'b0;
        end
        check_eq({tag, " busy"}, 32'(bus.req_ready), 32'd0);
        if (exp_lat > 1) check_eq({tag, " raddr"}, bus.mem_raddr, idx);
      end
      if (bus.mem_wen) begin
        wens++;
        check_eq({tag, " waddr"}, bus.mem_waddr, idx);
        check_eq({tag, " wdata"}, bus.mem_wdata, exp_wd);
      end
      if (bus.resp_valid) begin
        got_resp = 1;
        lat = c;
        check_eq({tag, " err"}, 32'(bus.resp_err), 32'(exp_lat == 1));
        check_eq({tag, " rdata"}, bus.resp_rdata, exp_rd);
      end
    end
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " wen count"}, wens, exp_wen);
  endtask

  initial begin
    int unsigned wen_before;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h9E37_79B9 * (i + 1);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = '0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst resp_err", 32'(bus.resp_err), 32'd0);
    check_eq("rst resp_rdata", bus.resp_rdata, 32'd0);
    check_eq("rst wen", 32'(bus.mem_wen), 32'd0);
    check_eq("rst raddr", bus.mem_raddr, 32'd0);
    check_eq("rst waddr", bus.mem_waddr, 32'd0);
    check_eq("rst wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    #1 check_eq("post-rst ready", 32'(bus.req_ready), 32'd1);

    // Word store then load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, "wst10");
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "wld10");

    // Sub-word read-modify-write
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 0, "wst20");
    do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, 0, "bst22");
    do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_5566, 0, "hst20");
    @(negedge clk);
    check_eq("rmw mem word 0x20", mem[8], 32'h11AA_5566);

    // Load extension
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h80F0_7F01, 0, "wst30");
    do_req(1'b0, 2'd0, 1'b0, 32'h31, 32'h0, 0, "lbs31");
    do_req(1'b0, 2'd0, 1'b0, 32'h32, 32'h0, 0, "lbs32");
    do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 0, "lhu32");
    do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 0, "lhs32");

    // Misaligned / illegal
    do_req(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 0, "lh41");
    do_req(1'b1, 2'd2, 1'b0, 32'h42, 32'hCAFE_F00D, 0, "sw42");
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0, "sz3");
    check_eq("err mem word 0x40", mem[16], ref_mem[16]);

    // Reset during READ of a byte store
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    wen_before = wen_seen;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h20;
    bus.req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_eq("rst-read ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst-read wen", 32'(bus.mem_wen), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rst-read ready held", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst-read no write", wen_seen, wen_before);
    check_eq("rst-read word", mem[8], 32'h11AA_5566);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "post-rst load");

    // req_valid held high across back-to-back requests
    do_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h0102_0304, 1, "hold0");
    do_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1, "hold1");
    do_req(1'b1, 2'd0, 1'b0, 32'h51, 32'h0000_00EE, 1, "hold2");
    do_req(1'b0, 2'd1, 1'b0, 32'h50, 32'h0, 1, "hold3");
    bus.req_valid = 1'b0;

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
             32'($urandom_range(255)), $urandom, 1'($urandom_range(1)), "rand");
    end
    bus.req_valid = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("total resp count", resp_seen, n_req);
    check_eq("total write count", wen_seen, n_wr);
    for (int i = 0; i < 64; i++) check_eq("final mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator that drives the word-wide data memory's read/write port on behalf of the core's execute stage. It accepts one byte/halfword/word load or store at a time over a valid/ready request port and converts byte addresses to word indices. Sub-word stores become a read-modify-write, because the memory has no byte enables. It returns load data extended per request, or an error for misaligned accesses, on a one-cycle response strobe.

## Interface
- WORD_ADDRESSED, 1, 1: memory address = req_addr[31:2] zero-extended; 0: memory address = {req_addr[31:2],2'b00}

- clk  in  1  system clock, all state on rising edge (memory samples on falling edge)
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE and rst low
- req_we  in  1  1 store, 0 load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion strobe
- resp_err  out  1  qualifies resp_valid; misaligned or illegal size
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_raddr  out  32  memory read address
- mem_rdata  in  32  memory read data; registered by memory on falling clk
- mem_waddr  out  32  memory write address
- mem_wdata  out  32  memory write data
- mem_wen  out  1  memory write enable

## Operation
- States: IDLE, READ, WRITE, RESP. Latch all req_* fields on accept (req_valid & req_ready at a rising edge).
- Misalignment: half with addr[0]=1; word with addr[1:0]≠0; size 3.
- Transitions out of IDLE on accept:
  - Misaligned -> RESP, err=1; no memory access, mem_wen never asserted.
  - Word store -> WRITE, mem_wdata = req_wdata.
  - Load or byte/half store -> READ.
- mem_raddr = mem_waddr = latched word address; both update only on accept.
- Transitions out of READ (sample mem_rdata at the rising edge ending READ):
  - Load -> RESP with extracted lane. Byte lane = addr[1:0], bits [8b+7:8b]. Half lane = addr[1], bits [16h+15:16h]. Little-endian. Extend per req_unsigned.
  - Sub-word store -> WRITE. mem_wdata = mem_rdata with the addressed lane replaced by req_wdata[7:0] or [15:0]; other bits unchanged.
- WRITE: mem_wen=1 for exactly this cycle. Next state is RESP.
- RESP: resp_valid=1 for one cycle; resp_err/resp_rdata valid. Next state is IDLE.
- resp_rdata and resp_err are registered, load on entry to RESP, and hold until the next entry.
- mem_wen is decoded from the state register only: high iff state==WRITE and rst low.

## Timing
- Accept at edge k; state during cycle k+1 onward:
  - Error: resp_valid in cycle k+1.
  - Word store: WRITE k+1, resp k+2.
  - Load: READ k+1, resp k+2.
  - Sub-word store: READ k+1, WRITE k+2, resp k+3.
- Memory write lands at the falling edge inside the WRITE cycle. A load issued after the resp of a store to the same word returns the new data.
- Back-to-back: req_ready is low from the accept edge through RESP; the next accept is earliest in the cycle after RESP.
- req_* changes while req_ready is low are ignored.
- Reset asserted (any state, asynchronously):
  - State goes to IDLE.
  - Outputs: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0; mem_raddr, mem_waddr and mem_wdata =0.
- Reset before the falling edge of WRITE suppresses the write. An in-flight RMW never writes partial data.
- First accept is possible at the first rising edge after rst deasserts.

## Test plan
- Word store 0xDEADBEEF at addr 0x10, then word load 0x10 -> mem_wen high one cycle with mem_waddr=0x4. Load resp at k+2 returns 0xDEADBEEF, err=0.
- Word at 0x20 = 0x11223344; byte store 0xAA to 0x22 -> READ, WRITE with mem_wdata=0x11AA3344, resp at k+3. Half store 0x5566 to 0x20 -> 0x11AA5566.
- Word 0x30 = 0x80F07F01: signed byte load 0x31 -> 0x0000007F; signed byte load 0x32 -> 0xFFFFFFF0; unsigned half load 0x32 -> 0x000080F0; signed half load 0x32 -> 0xFFFF80F0.
- Half load 0x41, word store 0x42, and size 3 at 0x40 -> each gives resp_err=1, resp_rdata=0 at k+1, mem_wen never high, memory unchanged.
- rst pulsed during the READ of a byte store to 0x20 -> mem_wen never asserts, word unchanged, req_ready=0 during reset. The first request after release completes normally.
- req_valid held high with 4 alternating loads/stores -> accepts only in IDLE, exactly one resp_valid per request, in order, no lost or duplicated memory writes.
